stage_ex_mc: RTL and testbench
==============================

Name: stage_ex_mc

Overview:
- Parametrised, multi-cycle execute stage for the RISC-V pipeline; sits between decode/register-read and memory stages.
- Single-cycle logic, arithmetic, shift and compare ops.
- Iterative unsigned multiply/divide through an internal state machine.
- Valid/ready handshakes on both sides, so upstream stalls while a long op runs.

Parameters:
- XLEN, 32, datapath width in bits (power of 2, >= 8).
- RADDR_W, 5, register address width.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of in-flight op and output register.
- in_valid  in  1  upstream presents an op.
- in_ready  out  1  stage accepts op this cycle.
- aluop  in  4  operation code (see Behaviour).
- opv1  in  XLEN  operand 1.
- opv2  in  XLEN  operand 2.
- reg_waddr_i  in  RADDR_W  destination register.
- we_i  in  1  write enable of op.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream consumes result this cycle.
- reg_waddr_o  out  RADDR_W  registered destination.
- we_o  out  1  registered write enable.
- wdata  out  XLEN  registered result.
- busy  out  1  high while state is MUL or DIV.

Behaviour:
- Opcodes:
  - 0 OR, 1 AND, 2 XOR.
  - 3 ADD, 4 SUB (mod 2**XLEN).
  - 5 SLL, 6 SRL, 7 SRA; shift amount is opv2[log2(XLEN)-1:0].
  - 8 SLT (signed), 9 SLTU; result is 0 or 1, zero-extended.
  - 10 MUL (low XLEN of product), 11 MULHU (high XLEN of unsigned product).
  - 12 DIVU, 13 REMU.
  - 14, 15: result 0, single-cycle.
- Accept condition: in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- States:
  - IDLE: on accepted single-cycle op, result, reg_waddr_i and we_i are registered at the clock edge; out_valid=1 next cycle (latency 1). On accepted op 10-13, operands, waddr and we are latched, counter=0, go to MUL or DIV.
  - MUL: radix-2 shift-add over 2*XLEN accumulator, one bit per cycle. After XLEN iterations (counter==XLEN-1), load wdata (low or high half), set out_valid, return to IDLE. Accept-to-out_valid latency is XLEN+1 cycles.
  - DIV: restoring shift-subtract, one quotient bit per cycle, same XLEN+1 latency.
    - Divide by zero (latched opv2==0) skips iteration: DIVU gives all ones, REMU gives the dividend. Result is ready in 1 cycle, like a single-cycle op.
- Output register:
  - Holds wdata, reg_waddr_o and we_o stable while out_valid && !out_ready.
  - Cleared to out_valid=0 on out_ready when no new result loads the same cycle.
  - A simultaneous consume and load (IDLE single-cycle op, or MUL/DIV completion) keeps out_valid=1 with the new data.
- Completion with out_valid=1 && !out_ready: FSM stays in MUL/DIV at final count (busy=1) until the register frees. No result is lost or overwritten.
- flush: state goes to IDLE, counter=0, out_valid=0, we_o=0. Any multi-cycle op is aborted. flush has priority over accept and completion.
- Reset (rst=1 at clock edge) overrides flush: state IDLE, out_valid=0, we_o=0, wdata=0, reg_waddr_o=0, busy=0, counter=0. in_ready=1 in the first cycle after reset.
- we_o is registered from the accepted we_i; reg_waddr_o=0 with we_i=1 is passed through, not suppressed.

Test Plan:
- Reset then OR opv1=0x0000_F0F0, opv2=0x0F0F_0000, waddr=3, we=1, out_ready=1 -> next cycle out_valid=1, wdata=0x0F0F_F0F0, reg_waddr_o=3, we_o=1.
- SRA opv1=0x8000_0000, opv2=4; SLTU 1 vs 0xFFFF_FFFF -> wdata=0xF800_0000, then 1, on back-to-back cycles with in_ready held high.
- MUL 0x0001_0003 x 0x0002_0005 accepted at cycle t -> in_ready=0 and busy=1 during t+1..t+32; out_valid=1 at t+33 with wdata=0x000B_000F. MULHU of the same operands -> 0x0000_0002.
- DIVU 100/7 -> wdata=14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFF_FFFF after 1 cycle; REMU 5/0 -> 5.
- Backpressure: out_ready=0 for 10 cycles after a single-cycle ADD result -> wdata/reg_waddr_o/we_o stable, in_ready=0. MUL completing while held stays busy until out_ready=1.
- flush at cycle t+10 of a DIV -> next cycle busy=0, out_valid=0, in_ready=1. A subsequent ADD 2+3 gives wdata=5. Repeat with rst mid-MUL -> all outputs zero.

Source files
------------

// File: rtl/stage_ex_mc.sv
// Multi-cycle execute stage: single-cycle ALU ops plus iterative unsigned
// multiply/divide, with valid/ready handshakes on both sides.
module stage_ex_mc #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         aluop,
    input  logic [XLEN-1:0]    opv1,
    input  logic [XLEN-1:0]    opv2,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic               we_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               we_o,
    output logic [XLEN-1:0]    wdata,
    output logic               busy
);

    localparam int SH_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]      opb_q, opb_d;
    logic                 sel_hi_q, sel_hi_d;
    logic [RADDR_W-1:0]   waddr_q, waddr_d;
    logic                 we_q, we_d;

    logic                 out_valid_q, out_valid_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;
    logic [RADDR_W-1:0]   waddr_o_q, waddr_o_d;
    logic                 we_o_q, we_o_d;

    logic                 can_load, accept, is_mc, div_zero;
    logic [SH_W-1:0]      shamt;
    logic [XLEN-1:0]      alu_res, mc_res;
    logic [XLEN:0]        mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0]    mul_next, div_next, step_next;
    logic                 load, load_we;
    logic [XLEN-1:0]      load_data;
    logic [RADDR_W-1:0]   load_waddr;

    assign can_load = !out_valid_q || out_ready;
    assign in_ready = (state_q == IDLE) && can_load && !flush;
    assign accept   = in_valid && in_ready;
    assign is_mc    = (aluop >= 4'd10) && (aluop <= 4'd13);
    // Divide by zero never enters the DIV loop; its result comes from the ALU path.
    assign div_zero = (aluop[3:1] == 3'b110) && (opv2 == '0);
    assign shamt    = opv2[SH_W-1:0];

    // Single-cycle result, including the fixed divide-by-zero answers.
    always_comb begin
        alu_res = '0;
        case (aluop)
            4'd0:    alu_res = opv1 | opv2;
            4'd1:    alu_res = opv1 & opv2;
            4'd2:    alu_res = opv1 ^ opv2;
            4'd3:    alu_res = opv1 + opv2;
            4'd4:    alu_res = opv1 - opv2;
            4'd5:    alu_res = opv1 << shamt;
            4'd6:    alu_res = opv1 >> shamt;
            4'd7:    alu_res = $signed(opv1) >>> shamt;
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(opv1) < $signed(opv2)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, opv1 < opv2};
            4'd12:   alu_res = '1;
            4'd13:   alu_res = opv1;
            default: alu_res = '0;
        endcase
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        step_next = (state_q == DIV) ? div_next : mul_next;
        mc_res    = sel_hi_q ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        sel_hi_d    = sel_hi_q;
        waddr_d     = waddr_q;
        we_d        = we_q;
        out_valid_d = out_valid_q;
        wdata_d     = wdata_q;
        waddr_o_d   = waddr_o_q;
        we_o_d      = we_o_q;
        load        = 1'b0;
        load_data   = '0;
        load_waddr  = waddr_q;
        load_we     = we_q;

        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            we_o_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_mc && !div_zero) begin
                            state_d  = aluop[2] ? DIV : MUL;
                            cnt_d    = '0;
                            acc_d    = {{XLEN{1'b0}}, aluop[2] ? opv1 : opv2};
                            opb_d    = aluop[2] ? opv2 : opv1;
                            sel_hi_d = aluop[0];
                            waddr_d  = reg_waddr_i;
                            we_d     = we_i;
                        end else begin
                            load       = 1'b1;
                            load_data  = alu_res;
                            load_waddr = reg_waddr_i;
                            load_we    = we_i;
                        end
                    end
                end
                MUL, DIV: begin
                    // The last step is only committed once the output register is free.
                    if (cnt_q == LAST) begin
                        if (can_load) begin
                            load      = 1'b1;
                            load_data = mc_res;
                            state_d   = IDLE;
                            cnt_d     = '0;
                        end
                    end else begin
                        acc_d = step_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (load) begin
                out_valid_d = 1'b1;
                wdata_d     = load_data;
                waddr_o_d   = load_waddr;
                we_o_d      = load_we;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            sel_hi_q    <= 1'b0;
            waddr_q     <= '0;
            we_q        <= 1'b0;
            out_valid_q <= 1'b0;
            wdata_q     <= '0;
            waddr_o_q   <= '0;
            we_o_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            sel_hi_q    <= sel_hi_d;
            waddr_q     <= waddr_d;
            we_q        <= we_d;
            out_valid_q <= out_valid_d;
            wdata_q     <= wdata_d;
            waddr_o_q   <= waddr_o_d;
            we_o_q      <= we_o_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign wdata       = wdata_q;
    assign reg_waddr_o = waddr_o_q;
    assign we_o        = we_o_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_stage_ex_mc.sv
// Self-checking bench for stage_ex_mc: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_stage_ex_mc;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 6;

    logic               clk = 1'b0;
    logic               rst, flush, in_valid, in_ready, we_i;
    logic [3:0]         aluop;
    logic [XLEN-1:0]    opv1, opv2, wdata;
    logic [RADDR_W-1:0] reg_waddr_i, reg_waddr_o;
    logic               out_valid, out_ready, we_o, busy;

    int checks = 0;
    int errors = 0;

    stage_ex_mc #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .aluop(aluop),
        .opv1(opv1), .opv2(opv2), .reg_waddr_i(reg_waddr_i), .we_i(we_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_waddr_o(reg_waddr_o), .we_o(we_o), .wdata(wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] modelResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sh;
        p  = {32'b0, a} * {32'b0, b};
        sh = int'(b[4:0]);
        case (op)
            4'd0:    return a | b;
            4'd1:    return a & b;
            4'd2:    return a ^ b;
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return p[31:0];
            4'd11:   return p[63:32];
            4'd12:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13:   return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int modelLatency(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd10 || op == 4'd11) return XLEN + 1;
        if ((op == 4'd12 || op == 4'd13) && b != 0) return XLEN + 1;
        return 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one op from a falling edge and holds it until accepted.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wa, input logic w);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; aluop = op; opv1 = a; opv2 = b; reg_waddr_i = wa; we_i = w;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic expectResult(input string tag, input logic [31:0] d, input logic [4:0] wa,
                                input logic w, input int lat);
        int n = 1;
        int viol = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            if (!busy || in_ready) viol++;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_latency"}, 64'(n), 64'(lat));
        checkOutput({tag, "_wdata"}, 64'(wdata), 64'(d));
        checkOutput({tag, "_waddr"}, 64'(reg_waddr_o), 64'(wa));
        checkOutput({tag, "_we"}, 64'(we_o), 64'(w));
        checkOutput({tag, "_busy_while_wait"}, 64'(viol), 64'd0);
    endtask

    task automatic checkHeld(input string tag, input logic [31:0] d, input logic [4:0] wa, input logic w);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_wdata"}, 64'(wdata), 64'(d));
        checkOutput({tag, "_waddr"}, 64'(reg_waddr_o), 64'(wa));
        checkOutput({tag, "_we"}, 64'(we_o), 64'(w));
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  wa;
        logic        w;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        aluop = '0; opv1 = '0; opv2 = '0; reg_waddr_i = '0; we_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_wdata", 64'(wdata), 64'd0);

        applyStimulus(4'd0, 32'h0000_F0F0, 32'h0F0F_0000, 5'd3, 1'b1);
        expectResult("or", 32'h0F0F_F0F0, 5'd3, 1'b1, 1);

        // SRA then SLTU on consecutive edges; the second accept consumes the first result.
        applyStimulus(4'd7, 32'h8000_0000, 32'd4, 5'd1, 1'b1);
        @(negedge clk);
        checkOutput("sra_valid", 64'(out_valid), 64'd1);
        checkOutput("sra_wdata", 64'(wdata), 64'hF800_0000);
        checkOutput("b2b_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; aluop = 4'd9; opv1 = 32'd1; opv2 = 32'hFFFF_FFFF; reg_waddr_i = 5'd2;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("sltu_valid", 64'(out_valid), 64'd1);
        checkOutput("sltu_wdata", 64'(wdata), 64'd1);
        checkOutput("sltu_waddr", 64'(reg_waddr_o), 64'd2);

        applyStimulus(4'd10, 32'h0001_0003, 32'h0002_0005, 5'd4, 1'b1);
        expectResult("mul", 32'h000B_000F, 5'd4, 1'b1, 33);
        applyStimulus(4'd11, 32'h0001_0003, 32'h0002_0005, 5'd5, 1'b1);
        expectResult("mulhu", 32'h0000_0002, 5'd5, 1'b1, 33);
        applyStimulus(4'd12, 32'd100, 32'd7, 5'd6, 1'b1);
        expectResult("divu", 32'd14, 5'd6, 1'b1, 33);
        applyStimulus(4'd13, 32'd100, 32'd7, 5'd7, 1'b1);
        expectResult("remu", 32'd2, 5'd7, 1'b1, 33);
        applyStimulus(4'd12, 32'd5, 32'd0, 5'd8, 1'b1);
        expectResult("divu_zero", 32'hFFFF_FFFF, 5'd8, 1'b1, 1);
        applyStimulus(4'd13, 32'd5, 32'd0, 5'd0, 1'b1);
        expectResult("remu_zero", 32'd5, 5'd0, 1'b1, 1);

        // Backpressure on a single-cycle result.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(4'd3, 32'd10, 32'd20, 5'd9, 1'b1);
        expectResult("bp_add", 32'd30, 5'd9, 1'b1, 1);
        repeat (10) checkHeld("bp_add_hold", 32'd30, 5'd9, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_add_drained", 64'(out_valid), 64'd0);

        // A MUL result parked in the output register stays put.
        applyStimulus(4'd10, 32'd3, 32'd5, 5'd10, 1'b0);
        out_ready = 1'b0;
        expectResult("bp_mul", 32'd15, 5'd10, 1'b0, 33);
        repeat (5) checkHeld("bp_mul_hold", 32'd15, 5'd10, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);

        // Flush ten cycles into a DIV.
        applyStimulus(4'd12, 32'd100, 32'd7, 5'd11, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(4'd3, 32'd2, 32'd3, 5'd12, 1'b1);
        expectResult("post_flush_add", 32'd5, 5'd12, 1'b1, 1);

        // Reset in the middle of a MUL.
        applyStimulus(4'd10, 32'd7, 32'd9, 5'd13, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mul_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mul_we", 64'(we_o), 64'd0);
        checkOutput("rst_mul_wdata", 64'(wdata), 64'd0);
        checkOutput("rst_mul_waddr", 64'(reg_waddr_o), 64'd0);
        checkOutput("rst_mul_busy", 64'(busy), 64'd0);
        checkOutput("rst_mul_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            wa = 5'($urandom_range(0, 31));
            w  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus(op, a, b, wa, w);
            expectResult("rand", modelResult(op, a, b), wa, w, modelLatency(op, b));
            if (!out_ready) begin
                repeat ($urandom_range(1, 4)) checkHeld("rand_hold", modelResult(op, a, b), wa, w);
                out_ready = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
